id_exe_skid_reg: RTL and testbench
==================================

Name: id_exe_skid_reg

Overview:
- Parametrised successor to the fixed ID-stage output register of the ARM pipeline; sits between the ID stage and the EXE stage.
- Carries the full decoded instruction bundle: PC, Rn/Rm values, exe_cmd, dest/src regs, shift operand, signed imm24, and control bits.
- Adds a valid/ready handshake through a 2-entry skid buffer, so EXE back-pressure never creates a combinational path back into ID.
- Adds flush for branch redirect, and retire/bubble counters for performance debug.

Parameters:
DATA_W, 32, width of pc, val_rn, val_rm
REG_AW, 4, register address width (dest_reg, src1, src2)
CMD_W, 4, exe_cmd width
SHOP_W, 12, shift_operand width
SIMM_W, 24, signed_imm_24 width
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-low; sampled on rising clk
in_valid  in  1  ID presents a valid bundle
in_ready  out  1  block can accept a bundle this cycle
pc_in, val_rn_in, val_rm_in  in  DATA_W each  bundle data
exe_cmd_in  in  CMD_W  bundle field
dest_reg_in, src1_in, src2_in  in  REG_AW each  bundle fields
shift_operand_in  in  SHOP_W  bundle field
signed_imm_24_in  in  SIMM_W  bundle field
imm_in, mem_read_in, mem_write_in, wb_enable_in, status_update_in, branch_taken_in  in  1 each  bundle fields
flush  in  1  discard all held and incoming bundles
out_valid  out  1  head bundle valid toward EXE
out_ready  in  1  EXE accepts the head bundle
pc_out … branch_taken_out  out  same widths as *_in  head bundle fields
retire_count  out  CNT_W  count of output handshakes
bubble_count  out  CNT_W  count of cycles with out_ready=1 and out_valid=0

Behaviour:
- Handshakes:
  - Input handshake (acc) = in_valid & in_ready.
  - Output handshake (ret) = out_valid & out_ready.
- Storage: main entry drives all *_out ports; skid entry holds the overflow bundle.
- FSM states: EMPTY, ONE, TWO. The state is registered.
- Status outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
  - Both are decoded from the state register only, with no combinational dependence on out_ready, in_valid or flush.
- Transitions when flush=0:
  - EMPTY: acc → ONE, main<=in.
  - ONE:
    - acc & !ret → TWO, skid<=in.
    - acc & ret → ONE, main<=in.
    - !acc & ret → EMPTY.
    - otherwise hold.
  - TWO: ret → ONE, main<=skid; otherwise hold. acc is impossible in TWO.
- Latency and ordering: a bundle accepted at edge N appears on *_out with out_valid=1 after edge N. Ordering is strictly FIFO.
- Throughput: 1 bundle/cycle sustained when out_ready=1.
- Flush, with priority over everything:
  - Next state is EMPTY, and any bundle offered in the same cycle is dropped.
  - A ret in the flush cycle still counts in retire_count, because EXE consumed it.
- Bubble masking: whenever out_valid=0, wb_enable_out, mem_read_out, mem_write_out, status_update_out and branch_taken_out read 0. All data fields hold their last values.
- Counters:
  - retire_count increments on ret.
  - bubble_count increments when out_ready=1 and out_valid=0.
  - Both wrap modulo 2^CNT_W; they are not cleared by flush.
- Reset (rst=0 at a rising edge):
  - State goes to EMPTY, so in_ready=1 and out_valid=0.
  - Both entries go to all-zero, so every *_out reads 0.
  - Both counters go to 0.
  - Reset mid-transfer discards both entries, and reset overrides flush.
- No X propagation: skid contents are only observable after a TWO→ONE transition.

Test Plan:
1. Reset, then stream MOV R0,#20 / MOV R1,#4096 / MOV R2,#0xC0000000 with out_ready=1 → on consecutive cycles: dest_reg_out 0/1/2, shift_operand_out 014/A01/103, exe_cmd_out 0001, imm_out=1, wb_enable_out=1; retire_count=3.
2. Offer ADDS R3,R2,R2 then SUB R4,R3,R1 with out_ready=0 → state TWO, in_ready=0. Then raise out_ready → ADDS is presented first (status_update_out=1, src1=src2=2), SUB next; no bundle lost or duplicated.
3. Hold state ONE, then assert in_valid and out_ready in the same cycle → main is replaced by the new bundle, state stays ONE, retire_count +1.
4. In state TWO, pulse flush while in_valid=1 → next cycle out_valid=0, in_ready=1, all control outs 0; the offered bundle never appears on *_out.
5. With out_ready=1 and in_valid=0 for 5 cycles → bubble_count=5. Then preload the counter to 2^CNT_W−1 (small CNT_W=4 build) and run 1 more bubble cycle → bubble_count wraps to 0.
6. Drive rst=0 for one edge while in state TWO with nonzero counters → next cycle all outputs 0, in_ready=1. Verify that rst only acts at a clock edge (synchronous).

Source files
------------

// File: rtl/id_exe_skid_reg.sv
// ID/EXE pipeline register with a 2-entry skid buffer, flush and perf counters.
// Status outputs decode only the state register, so EXE back-pressure never reaches ID combinationally.
module id_exe_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned SHOP_W = 12,
  parameter int unsigned SIMM_W = 24,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic [REG_AW-1:0] dest_reg_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic [SHOP_W-1:0] shift_operand_in,
  input  logic [SIMM_W-1:0] signed_imm_24_in,
  input  logic              imm_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_enable_in,
  input  logic              status_update_in,
  input  logic              branch_taken_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [CMD_W-1:0]  exe_cmd_out,
  output logic [REG_AW-1:0] dest_reg_out,
  output logic [REG_AW-1:0] src1_out,
  output logic [REG_AW-1:0] src2_out,
  output logic [SHOP_W-1:0] shift_operand_out,
  output logic [SIMM_W-1:0] signed_imm_24_out,
  output logic              imm_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_enable_out,
  output logic              status_update_out,
  output logic              branch_taken_out,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [CMD_W-1:0]  exe_cmd;
    logic [REG_AW-1:0] dest_reg;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [SHOP_W-1:0] shift_operand;
    logic [SIMM_W-1:0] signed_imm_24;
    logic              imm;
    logic              mem_read;
    logic              mem_write;
    logic              wb_enable;
    logic              status_update;
    logic              branch_taken;
  } bundle_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q;
  bundle_t          main_q, skid_q, in_bundle;
  logic [CNT_W-1:0] retire_q, bubble_q;
  logic             acc, ret;

  always_comb begin
    in_bundle               = '0;
    in_bundle.pc            = pc_in;
    in_bundle.val_rn        = val_rn_in;
    in_bundle.val_rm        = val_rm_in;
    in_bundle.exe_cmd       = exe_cmd_in;
    in_bundle.dest_reg      = dest_reg_in;
    in_bundle.src1          = src1_in;
    in_bundle.src2          = src2_in;
    in_bundle.shift_operand = shift_operand_in;
    in_bundle.signed_imm_24 = signed_imm_24_in;
    in_bundle.imm           = imm_in;
    in_bundle.mem_read      = mem_read_in;
    in_bundle.mem_write     = mem_write_in;
    in_bundle.wb_enable     = wb_enable_in;
    in_bundle.status_update = status_update_in;
    in_bundle.branch_taken  = branch_taken_in;
  end

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StTwo);
  assign acc       = in_valid & in_ready;
  assign ret       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StEmpty;
      main_q   <= '0;
      skid_q   <= '0;
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      // Counters run independently of flush: a flushed head still retired if EXE took it.
      if (ret) retire_q <= retire_q + CNT_W'(1);
      if (out_ready && !out_valid) bubble_q <= bubble_q + CNT_W'(1);

      if (flush) begin
        state_q <= StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (acc) begin
              state_q <= StOne;
              main_q  <= in_bundle;
            end
          end
          StOne: begin
            if (acc && !ret) begin
              state_q <= StTwo;
              skid_q  <= in_bundle;
            end else if (acc && ret) begin
              main_q <= in_bundle;
            end else if (ret) begin
              state_q <= StEmpty;
            end
          end
          StTwo: begin
            if (ret) begin
              state_q <= StOne;
              main_q  <= skid_q;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  assign pc_out            = main_q.pc;
  assign val_rn_out        = main_q.val_rn;
  assign val_rm_out        = main_q.val_rm;
  assign exe_cmd_out       = main_q.exe_cmd;
  assign dest_reg_out      = main_q.dest_reg;
  assign src1_out          = main_q.src1;
  assign src2_out          = main_q.src2;
  assign shift_operand_out = main_q.shift_operand;
  assign signed_imm_24_out = main_q.signed_imm_24;
  assign imm_out           = main_q.imm;
  // Side-effecting controls are masked during bubbles; data fields keep their last value.
  assign mem_read_out      = main_q.mem_read & out_valid;
  assign mem_write_out     = main_q.mem_write & out_valid;
  assign wb_enable_out     = main_q.wb_enable & out_valid;
  assign status_update_out = main_q.status_update & out_valid;
  assign branch_taken_out  = main_q.branch_taken & out_valid;
  assign retire_count      = retire_q;
  assign bubble_count      = bubble_q;

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Directed bench for id_exe_skid_reg: streaming, back-pressure, flush, counters, reset.
// A second instance with CNT_W=4 shares all inputs to exercise counter wrap.
module tb_id_exe_skid_reg;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] pc_in, val_rn_in, val_rm_in, pc_out, val_rn_out, val_rm_out;
  logic [3:0]  exe_cmd_in, dest_reg_in, src1_in, src2_in;
  logic [3:0]  exe_cmd_out, dest_reg_out, src1_out, src2_out;
  logic [11:0] shift_operand_in, shift_operand_out;
  logic [23:0] signed_imm_24_in, signed_imm_24_out;
  logic        imm_in, mem_read_in, mem_write_in, wb_enable_in, status_update_in, branch_taken_in;
  logic        imm_out, mem_read_out, mem_write_out, wb_enable_out, status_update_out;
  logic        branch_taken_out;
  logic [31:0] retire_count, bubble_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_pc_out, s_val_rn_out, s_val_rm_out;
  logic [3:0]  s_exe_cmd_out, s_dest_reg_out, s_src1_out, s_src2_out;
  logic [11:0] s_shift_operand_out;
  logic [23:0] s_signed_imm_24_out;
  logic        s_imm_out, s_mem_read_out, s_mem_write_out, s_wb_enable_out;
  logic        s_status_update_out, s_branch_taken_out;
  logic [3:0]  s_retire_count, s_bubble_count;

  int checks   = 0;
  int failures = 0;

  id_exe_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .exe_cmd_in(exe_cmd_in),
    .dest_reg_in(dest_reg_in), .src1_in(src1_in), .src2_in(src2_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .imm_in(imm_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_enable_in(wb_enable_in), .status_update_in(status_update_in),
    .branch_taken_in(branch_taken_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .exe_cmd_out(exe_cmd_out), .dest_reg_out(dest_reg_out), .src1_out(src1_out),
    .src2_out(src2_out), .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out), .imm_out(imm_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_enable_out(wb_enable_out),
    .status_update_out(status_update_out), .branch_taken_out(branch_taken_out),
    .retire_count(retire_count), .bubble_count(bubble_count)
  );

  id_exe_skid_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .exe_cmd_in(exe_cmd_in),
    .dest_reg_in(dest_reg_in), .src1_in(src1_in), .src2_in(src2_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .imm_in(imm_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_enable_in(wb_enable_in), .status_update_in(status_update_in),
    .branch_taken_in(branch_taken_in), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .pc_out(s_pc_out), .val_rn_out(s_val_rn_out),
    .val_rm_out(s_val_rm_out), .exe_cmd_out(s_exe_cmd_out), .dest_reg_out(s_dest_reg_out),
    .src1_out(s_src1_out), .src2_out(s_src2_out), .shift_operand_out(s_shift_operand_out),
    .signed_imm_24_out(s_signed_imm_24_out), .imm_out(s_imm_out),
    .mem_read_out(s_mem_read_out), .mem_write_out(s_mem_write_out),
    .wb_enable_out(s_wb_enable_out), .status_update_out(s_status_update_out),
    .branch_taken_out(s_branch_taken_out), .retire_count(s_retire_count),
    .bubble_count(s_bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [3:0] cmd, input logic [3:0] dst,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [11:0] shop,
                       input logic im, input logic wb, input logic su, input logic bt);
    pc_in = pc;  val_rn_in = 32'h1000 + pc;  val_rm_in = 32'h2000 + pc;
    exe_cmd_in = cmd;  dest_reg_in = dst;  src1_in = s1;  src2_in = s2;
    shift_operand_in = shop;  signed_imm_24_in = 24'h0;  imm_in = im;
    mem_read_in = 1'b0;  mem_write_in = 1'b0;  wb_enable_in = wb;
    status_update_in = su;  branch_taken_in = bt;
  endtask

  initial begin
    rst = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;  flush = 1'b0;
    drive(32'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_retire", retire_count, 0);
    check("rst_bubble", bubble_count, 0);
    check("rst_pc", pc_out, 0);
    rst = 1'b1;

    // MOV stream at full rate
    out_ready = 1'b1;  in_valid = 1'b1;
    drive(32'h0, 4'b0001, 4'd0, 4'd0, 4'd0, 12'h014, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("mov0_valid", out_valid, 1);
    check("mov0_dest", dest_reg_out, 0);
    check("mov0_shop", shift_operand_out, 12'h014);
    check("mov0_cmd", exe_cmd_out, 4'b0001);
    check("mov0_imm", imm_out, 1);
    check("mov0_wb", wb_enable_out, 1);
    drive(32'h4, 4'b0001, 4'd1, 4'd0, 4'd0, 12'hA01, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("mov1_dest", dest_reg_out, 1);
    check("mov1_shop", shift_operand_out, 12'hA01);
    check("mov1_pc", pc_out, 32'h4);
    drive(32'h8, 4'b0001, 4'd2, 4'd0, 4'd0, 12'h103, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("mov2_dest", dest_reg_out, 2);
    check("mov2_shop", shift_operand_out, 12'h103);
    check("mov2_rn", val_rn_out, 32'h1008);
    in_valid = 1'b0;
    step();
    check("mov_retire", retire_count, 3);
    check("mov_drained", out_valid, 0);
    check("mov_wb_masked", wb_enable_out, 0);
    check("mov_data_held", dest_reg_out, 2);

    // Back-pressure fills the skid entry
    out_ready = 1'b0;  in_valid = 1'b1;
    drive(32'hC, 4'b0010, 4'd3, 4'd2, 4'd2, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("adds_one_valid", out_valid, 1);
    drive(32'h10, 4'b0100, 4'd4, 4'd3, 4'd1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("two_in_ready", in_ready, 0);
    check("two_head_dest", dest_reg_out, 3);
    in_valid = 1'b0;  out_ready = 1'b1;
    check("adds_su", status_update_out, 1);
    check("adds_src1", src1_out, 2);
    check("adds_src2", src2_out, 2);
    check("adds_cmd", exe_cmd_out, 4'b0010);
    step();
    check("sub_dest", dest_reg_out, 4);
    check("sub_src1", src1_out, 3);
    check("sub_src2", src2_out, 1);
    check("sub_su", status_update_out, 0);
    check("sub_in_ready", in_ready, 1);
    check("sub_retire", retire_count, 4);
    step();
    check("bp_retire", retire_count, 5);
    check("bp_empty", out_valid, 0);

    // Replace-in-place from ONE
    out_ready = 1'b0;  in_valid = 1'b1;
    drive(32'h14, 4'b0001, 4'd5, 4'd0, 4'd0, 12'h001, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("x_dest", dest_reg_out, 5);
    out_ready = 1'b1;
    drive(32'h18, 4'b0001, 4'd6, 4'd0, 4'd0, 12'h002, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("y_dest", dest_reg_out, 6);
    check("y_valid", out_valid, 1);
    check("y_in_ready", in_ready, 1);
    check("y_retire", retire_count, 6);

    // Flush from TWO drops held and offered bundles
    out_ready = 1'b0;
    drive(32'h1C, 4'b0001, 4'd7, 4'd0, 4'd0, 12'h003, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("z_in_ready", in_ready, 0);
    flush = 1'b1;
    drive(32'h20, 4'b0101, 4'd8, 4'd1, 4'd1, 12'h004, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_bt", branch_taken_out, 0);
    check("flush_wb", wb_enable_out, 0);
    check("flush_su", status_update_out, 0);
    flush = 1'b0;  in_valid = 1'b0;
    step();
    check("flush_still_empty", out_valid, 0);
    check("flush_data_held", dest_reg_out, 6);
    check("flush_retire", retire_count, 6);

    // Flush coinciding with a retire still counts it
    in_valid = 1'b1;
    drive(32'h24, 4'b0001, 4'd9, 4'd0, 4'd0, 12'h005, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;  flush = 1'b1;  out_ready = 1'b1;
    step();
    check("flush_ret_retire", retire_count, 7);
    check("flush_ret_valid", out_valid, 0);
    flush = 1'b0;

    // Synchronous reset from TWO, also overriding flush
    out_ready = 1'b0;  in_valid = 1'b1;
    drive(32'h28, 4'b0001, 4'd10, 4'd0, 4'd0, 12'h006, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h2C, 4'b0001, 4'd11, 4'd0, 4'd0, 12'h007, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_rst_in_ready", in_ready, 0);
    in_valid = 1'b0;  rst = 1'b0;  flush = 1'b1;
    #3;
    check("rst_sync_valid", out_valid, 1);
    check("rst_sync_retire", retire_count, 7);
    check("rst_sync_dest", dest_reg_out, 10);
    step();
    check("rst2_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_retire", retire_count, 0);
    check("rst2_bubble", bubble_count, 0);
    check("rst2_dest", dest_reg_out, 0);
    check("rst2_pc", pc_out, 0);
    check("rst2_shop", shift_operand_out, 0);
    check("rst2_imm", imm_out, 0);
    rst = 1'b1;  flush = 1'b0;

    // Bubble counting and wrap on the narrow-counter instance
    out_ready = 1'b1;
    repeat (5) step();
    check("bubble5", bubble_count, 5);
    check("bubble5_small", s_bubble_count, 5);
    repeat (10) step();
    check("bubble15_small", s_bubble_count, 15);
    step();
    check("bubble_wrap_small", s_bubble_count, 0);
    check("bubble16", bubble_count, 16);
    check("bubble_retire", retire_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
